iob_bus_merge: RTL and testbench
================================

IOB_BUS_MERGE -- requirements
Module: iob_bus_merge

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width (multiple of 8).
REQ-002 Derived widths SHALL be: REQ_W = 1+ADDR_W+DATA_W+DATA_W/8, packed {avalid, address, wdata, wstrb} MSB to LSB; RESP_W = DATA_W+2, packed {rdata, ready, rvalid}.
REQ-003 Clock/reset: one clock; reset is asynchronous and active-low.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- resetn  in  1  async active-low reset.
- ibus_req  in  REQ_W  CPU instruction request (master 0).
- ibus_resp  out  RESP_W  response to master 0.
- dbus_req  in  REQ_W  CPU data request (master 1).
- dbus_resp  out  RESP_W  response to master 1.
- mem_req  out  REQ_W  merged request to the single memory port.
- mem_resp  in  RESP_W  memory response.

Function
REQ-005 A master's request SHALL be pending when its avalid=1; a request is a write when wstrb!=0, otherwise a read.
REQ-006 A request SHALL be accepted in the cycle where it is forwarded on mem_req with avalid=1 and mem_resp.ready=1.
REQ-007 FSM states SHALL be IDLE, HOLD, RD_WAIT; owner register (1 bit) names the served master.
REQ-008 IDLE: if any master is pending, the arbitration winner's request SHALL be forwarded combinationally to mem_req (zero-cycle latency); the loser sees ready=0.
REQ-009 IDLE with accepted write -> IDLE; accepted read -> RD_WAIT; not accepted -> HOLD; owner := winner in all three cases.
REQ-010 HOLD: only owner's request SHALL be forwarded (grant locked even if the other master asserts); accepted write -> IDLE, accepted read -> RD_WAIT.
REQ-011 HOLD with owner's avalid dropped SHALL return to IDLE with mem_req.avalid=0.
REQ-012 RD_WAIT: mem_req.avalid SHALL be 0, ready SHALL be 0 to both masters; on mem_resp.rvalid=1 -> IDLE, with no new request issued that cycle.
REQ-013 mem_resp.ready SHALL be routed only to the currently forwarded master; rdata and rvalid SHALL be routed only to owner in RD_WAIT; every other master sees rvalid=0, ready=0, rdata=0.
REQ-014 mem_resp.rvalid outside RD_WAIT SHALL be ignored (not routed).
REQ-015 mem_req SHALL be all-zero whenever no request is forwarded.
REQ-016 At most one read SHALL be outstanding; writes produce no rvalid.

Reset
REQ-017 resetn=0 SHALL asynchronously force state=IDLE, owner=0, priority pointer=0 (ibus preferred), mem_req avalid=0.
REQ-018 Reset mid-transaction SHALL abandon HOLD/RD_WAIT state; a late rvalid after reset release SHALL be ignored per REQ-014.

Configuration
REQ-019 Macro IOB_BUS_MERGE_RR_EN defined: round-robin arbitration; the pointer is updated on every acceptance so the master just accepted gets lowest priority next.
REQ-020 Macro undefined: fixed priority, dbus (master 1) always wins in IDLE; the pointer register is not implemented.

Verification
REQ-021 Single ibus read addr 0x100, memory ready same cycle, rvalid 2 cycles later, rdata 0xDEADBEEF -> ibus_resp rvalid=1 with 0xDEADBEEF, dbus_resp rvalid=0, state back to IDLE.
REQ-022 dbus write addr 0x80 wstrb 0xF, ready held low 3 cycles then high -> mem_req stable for 4 cycles, dbus ready only in 4th cycle, ibus request raised in cycle 2 receives no ready.
REQ-023 Both masters pend reads continuously, ready=1, rvalid 1 cycle later: RR_EN -> grants alternate i,d,i,d; without macro -> dbus granted every time, ibus starved.
REQ-024 Spurious mem_resp rvalid=1 in IDLE -> both rvalid outputs stay 0, state unchanged.
REQ-025 resetn pulsed low during RD_WAIT, then rvalid=1 -> no rvalid to either master; next ibus read forwarded immediately in IDLE.

Source files
------------

// File: rtl/iob_bus_merge.sv
// Two-master (ibus/dbus) to one-memory-port request merger with one outstanding read.
// Define IOB_BUS_MERGE_RR_EN for round-robin arbitration; default is fixed priority (dbus wins).
module iob_bus_merge #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W/8,
  localparam int RESP_W = DATA_W + 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REQ_W-1:0]  ibus_req,
  output logic [RESP_W-1:0] ibus_resp,
  input  logic [REQ_W-1:0]  dbus_req,
  output logic [RESP_W-1:0] dbus_resp,
  output logic [REQ_W-1:0]  mem_req,
  input  logic [RESP_W-1:0] mem_resp
);
  typedef enum logic [1:0] {IDLE, HOLD, RD_WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              pend_i, pend_d, win, sel, fwd, acc, wr;
  logic              mem_ready, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [REQ_W-1:0]  sel_req;

  assign pend_i     = ibus_req[REQ_W-1];
  assign pend_d     = dbus_req[REQ_W-1];
  assign mem_rdata  = mem_resp[RESP_W-1:2];
  assign mem_ready  = mem_resp[1];
  assign mem_rvalid = mem_resp[0];

`ifdef IOB_BUS_MERGE_RR_EN
  // ptr_q names the preferred master when both are pending.
  logic ptr_q, ptr_d;
  assign win   = (pend_i && pend_d) ? ptr_q : pend_d;
  assign ptr_d = acc ? ~sel : ptr_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
`else
  assign win = pend_d;
`endif

  always_comb begin
    sel     = (state_q == HOLD) ? owner_q : win;
    sel_req = sel ? dbus_req : ibus_req;
    // Reset is folded in so mem_req is quiet while resetn is low.
    fwd     = resetn && (state_q != RD_WAIT) && sel_req[REQ_W-1];
    acc     = fwd && mem_ready;
    wr      = |sel_req[DATA_W/8-1:0];
    mem_req = fwd ? sel_req : '0;

    ibus_resp = '0;
    dbus_resp = '0;
    if (fwd) begin
      if (sel) dbus_resp[1] = mem_ready;
      else     ibus_resp[1] = mem_ready;
    end
    if (state_q == RD_WAIT) begin
      if (owner_q) dbus_resp = {mem_rdata, 1'b0, mem_rvalid};
      else         ibus_resp = {mem_rdata, 1'b0, mem_rvalid};
    end

    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: if (fwd) begin
        owner_d = sel;
        state_d = acc ? (wr ? IDLE : RD_WAIT) : HOLD;
      end
      HOLD: begin
        if (!fwd)     state_d = IDLE;
        else if (acc) state_d = wr ? IDLE : RD_WAIT;
      end
      RD_WAIT: if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
endmodule

// File: tb/tb_iob_bus_merge.sv
// Randomized + directed bench for iob_bus_merge against a transaction-level model.
module tb_iob_bus_merge;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W/8;
  localparam int RESP_W = DATA_W + 2;
`ifdef IOB_BUS_MERGE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [REQ_W-1:0]  ibus_req = '0, dbus_req = '0, mem_req;
  logic [RESP_W-1:0] ibus_resp, dbus_resp, mem_resp = '0;

  int n_cmp = 0, n_bad = 0;
  // model: locked = master holding the grant (-1 none), rd_out = master owed a read (-1 none)
  int locked = -1, rd_out = -1, pref = 0;
  int mdl_gnt, dut_gnt;

  always #5 clk = ~clk;

  iob_bus_merge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn),
    .ibus_req(ibus_req), .ibus_resp(ibus_resp),
    .dbus_req(dbus_req), .dbus_resp(dbus_resp),
    .mem_req(mem_req), .mem_resp(mem_resp)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk(input bit v, input logic [ADDR_W-1:0] a,
                                          input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
    return {v, a, d, s};
  endfunction

  // Called at a negedge with inputs already applied; checks, then advances to the next negedge.
  task automatic step();
    logic [REQ_W-1:0]  rq[2];
    logic [RESP_W-1:0] er[2];
    int cand;
    #1;
    if (!resetn) begin locked = -1; rd_out = -1; pref = 0; end
    rq[0] = ibus_req;
    rq[1] = dbus_req;
    cand = -1;
    if (resetn && rd_out < 0) begin
      if (locked >= 0) begin
        if (rq[locked][REQ_W-1]) cand = locked;
      end else if (rq[0][REQ_W-1] && rq[1][REQ_W-1]) cand = RR ? pref : 1;
      else if (rq[0][REQ_W-1]) cand = 0;
      else if (rq[1][REQ_W-1]) cand = 1;
    end
    for (int m = 0; m < 2; m++) begin
      er[m] = '0;
      if (cand == m) er[m][1] = mem_resp[1];
      if (rd_out == m) begin
        er[m][0] = mem_resp[0];
        er[m][RESP_W-1:2] = mem_resp[RESP_W-1:2];
      end
    end
    chk("mem_req", mem_req, (cand >= 0) ? rq[cand] : '0);
    chk("ibus_resp", ibus_resp, er[0]);
    chk("dbus_resp", dbus_resp, er[1]);
    mdl_gnt = (cand >= 0 && mem_resp[1]) ? cand : -1;
    dut_gnt = (mem_req[REQ_W-1] && mem_resp[1]) ? ((mem_req == dbus_req) ? 1 : 0) : -1;
    @(posedge clk);
    if (resetn) begin
      if (rd_out >= 0) begin
        if (mem_resp[0]) rd_out = -1;
      end else if (cand >= 0) begin
        if (mem_resp[1]) begin
          locked = -1;
          pref = 1 - cand;
          if (rq[cand][DATA_W/8-1:0] == '0) rd_out = cand;
        end else locked = cand;
      end else locked = -1;
    end
    @(negedge clk);
  endtask

  function automatic logic [REQ_W-1:0] rnd_req();
    logic [DATA_W/8-1:0] s;
    s = ($urandom_range(0, 1) == 0) ? '0 : (DATA_W/8)'($urandom());
    return mk(1'b1, ADDR_W'($urandom_range(0, 15) * 4), DATA_W'($urandom()), s);
  endfunction

  initial begin
    int k;
    @(negedge clk);
    // reset with a pending request: nothing may leak out
    ibus_req = mk(1'b1, 32'h40, '0, '0);
    step();
    ibus_req = '0;
    step();

    // single ibus read, rvalid two cycles after acceptance
    resetn = 1'b1;
    ibus_req = mk(1'b1, 32'h100, '0, '0);
    mem_resp = {32'h0, 1'b1, 1'b0};
    step();
    ibus_req = '0;
    mem_resp = '0;
    step();
    mem_resp = {32'hDEADBEEF, 1'b0, 1'b1};
    #1 chk("rd_ibus", ibus_resp, {32'hDEADBEEF, 2'b01});
    chk("rd_dbus", dbus_resp, '0);
    step();
    mem_resp = '0;

    // dbus write stalled 3 cycles; ibus arrives in cycle 2 and must wait
    dbus_req = mk(1'b1, 32'h80, 32'h12345678, 4'hF);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) ibus_req = mk(1'b1, 32'h200, '0, '0);
      mem_resp = {32'h0, (c == 3), 1'b0};
      #1 chk("wr_hold", mem_req, mk(1'b1, 32'h80, 32'h12345678, 4'hF));
      chk("wr_dready", dbus_resp[1], (c == 3));
      chk("wr_iready", ibus_resp[1], 1'b0);
      step();
    end
    dbus_req = '0;
    ibus_req = '0;
    mem_resp = '0;
    step();

    // spurious rvalid while idle
    mem_resp = {32'hCAFEF00D, 1'b0, 1'b1};
    step();
    step();

    // reset pulsed during RD_WAIT, then a late rvalid
    ibus_req = mk(1'b1, 32'h300, '0, '0);
    mem_resp = {32'h0, 1'b1, 1'b0};
    step();
    ibus_req = '0;
    mem_resp = '0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    mem_resp = {32'h55AA55AA, 1'b0, 1'b1};
    #1 chk("late_rv_i", ibus_resp[0], 1'b0);
    chk("late_rv_d", dbus_resp[0], 1'b0);
    step();
    ibus_req = mk(1'b1, 32'h304, '0, '0);
    mem_resp = {32'h0, 1'b1, 1'b0};
    #1 chk("post_rst_fwd", mem_req, mk(1'b1, 32'h304, '0, '0));
    step();
    mem_resp = {32'h0, 1'b0, 1'b1};
    ibus_req = '0;
    step();

    // both masters pend reads continuously; grant order depends on arbitration mode
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    ibus_req = mk(1'b1, 32'h10, '0, '0);
    dbus_req = mk(1'b1, 32'h20, '0, '0);
    mem_resp = {32'h1111, 1'b1, 1'b1};
    k = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (dut_gnt >= 0 || mdl_gnt >= 0) begin
        chk("contend_gnt", 32'(dut_gnt), RR ? 32'(k % 2) : 32'd1);
        k++;
      end
    end
    chk("contend_cnt", 32'(k), 32'd6);

    // random traffic, occasional resets
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(0, 199) != 0);
      mem_resp = {DATA_W'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0)};
      step();
      for (int m = 0; m < 2; m++) begin
        logic [REQ_W-1:0] cur;
        cur = m ? dbus_req : ibus_req;
        if (cur[REQ_W-1] && mdl_gnt == m)
          cur = ($urandom_range(0, 2) != 0) ? rnd_req() : '0;
        else if (cur[REQ_W-1]) begin
          if ($urandom_range(0, 19) == 0) cur = '0;
        end else if ($urandom_range(0, 1) == 0) cur = rnd_req();
        if (m == 1) dbus_req = cur;
        else        ibus_req = cur;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
